// File: rtl/fifo_push_gen.sv
// rtl/fifo_push_gen.sv - write-side FIFO traffic generator with burst/gap and drain delay
//
// Purpose:
//   Pushes a run-time number of words into a FIFO write port, honouring wfull
//   back-pressure. Data is either a Galois LFSR stream or an incrementing count.
//   In burst mode, idle gaps are inserted between bursts. After the last push, the
//   FSM waits DONE_DELAY cycles and then raises a sticky wr_done.
//
// Ports:
//   wclk        write-domain clock
//   wrst_n      synchronous active-low reset
//   start       start pulse, honoured in IDLE or DONE only
//   num_cmds    words to push (sampled on accepted start)
//   mode        00 LFSR, 01 burst LFSR, 10 incrementing, 11 as 00
//   burst_len   words per burst in mode 01 (0 acts as 1)
//   gap_len     idle cycles between bursts in mode 01
//   wfull       FIFO full flag
//   winc        FIFO write enable
//   wdata       FIFO write data (zero when winc is low)
//   busy        high in PUSH, GAP, DRAIN
//   wr_done     sticky completion flag
//   push_count  accepted pushes since the last start

module fifo_push_gen #(
  parameter int          DATA_WIDTH = 8,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_00A5,
  parameter int          DONE_DELAY = 10,
  parameter int          GAP_WIDTH  = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_cmds,
  input  logic [1:0]            mode,
  input  logic [GAP_WIDTH-1:0]  burst_len,
  input  logic [GAP_WIDTH-1:0]  gap_len,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  wr_done,
  output logic [CNT_WIDTH-1:0]  push_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  localparam int DRAIN_W = (DONE_DELAY > 1) ? $clog2(DONE_DELAY) : 1;
  localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(DONE_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE    = GAP_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE  = DATA_WIDTH'(1);

  state_t state, state_next;

  // Command parameters captured on an accepted start
  logic [CNT_WIDTH-1:0]  num_cmds_q;
  logic [1:0]            mode_q;
  logic [GAP_WIDTH-1:0]  burst_len_q;
  logic [GAP_WIDTH-1:0]  gap_len_q;

  // Datapath state
  logic [CNT_WIDTH-1:0]  push_count_q;
  logic [31:0]           lfsr;
  logic [DATA_WIDTH-1:0] inc_cnt;
  logic [GAP_WIDTH-1:0]  burst_cnt;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [DRAIN_W-1:0]    drain_cnt;

  // Combinational helpers
  logic                  start_ok;
  logic                  accept;
  logic                  last_push;
  logic                  burst_mode;
  logic                  incr_mode;
  logic [GAP_WIDTH-1:0]  burst_eff;
  logic                  burst_end;
  logic [DATA_WIDTH-1:0] word;
  logic [31:0]           lfsr_next;

  always_comb begin
    start_ok   = start && ((state == IDLE) || (state == DONE));
    accept     = (state == PUSH) && !wfull;
    last_push  = accept && ((push_count_q + CNT_ONE) == num_cmds_q);
    burst_mode = (mode_q == 2'b01);
    incr_mode  = (mode_q == 2'b10);
    // A zero burst length would otherwise never terminate a burst
    burst_eff  = (burst_len_q == '0) ? GAP_ONE : burst_len_q;
    burst_end  = accept && burst_mode && ((burst_cnt + GAP_ONE) == burst_eff);
    word       = incr_mode ? inc_cnt : lfsr[DATA_WIDTH-1:0];
    lfsr_next  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);
  end

  // State register
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          state_next = (num_cmds == '0) ? DRAIN : PUSH;
        end
      end
      PUSH: begin
        // Completion wins over a burst boundary so the final burst never gaps
        if (last_push) begin
          state_next = DRAIN;
        end else if (burst_end && (gap_len_q != '0)) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == (gap_len_q - GAP_ONE)) begin
          state_next = PUSH;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture and datapath counters
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      num_cmds_q   <= '0;
      mode_q       <= 2'b00;
      burst_len_q  <= '0;
      gap_len_q    <= '0;
      push_count_q <= '0;
      lfsr         <= LFSR_SEED;
      inc_cnt      <= '0;
      burst_cnt    <= '0;
      gap_cnt      <= '0;
      drain_cnt    <= '0;
    end else if (start_ok) begin
      num_cmds_q   <= num_cmds;
      mode_q       <= mode;
      burst_len_q  <= burst_len;
      gap_len_q    <= gap_len;
      push_count_q <= '0;
      lfsr         <= LFSR_SEED;
      inc_cnt      <= '0;
      burst_cnt    <= '0;
      gap_cnt      <= '0;
      drain_cnt    <= '0;
    end else begin
      // Everything that tracks pushes advances only on an accepted push, so a
      // wfull stall freezes the data stream exactly where it was.
      if (accept) begin
        push_count_q <= push_count_q + CNT_ONE;
        lfsr         <= lfsr_next;
        inc_cnt      <= inc_cnt + DATA_ONE;
        if (burst_mode) begin
          burst_cnt <= burst_end ? '0 : (burst_cnt + GAP_ONE);
        end
      end
      gap_cnt   <= (state == GAP)   ? (gap_cnt + GAP_ONE) : '0;
      drain_cnt <= (state == DRAIN) ? (drain_cnt + DRAIN_W'(1)) : '0;
    end
  end

  // Outputs
  always_comb begin
    winc       = accept;
    wdata      = accept ? word : '0;
    busy       = (state == PUSH) || (state == GAP) || (state == DRAIN);
    wr_done    = (state == DONE);
    push_count = push_count_q;
  end

endmodule

// File: tb/tb_fifo_push_gen.sv
// tb/tb_fifo_push_gen.sv - scoreboard testbench for fifo_push_gen

module tb_fifo_push_gen;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        start;
  logic [15:0] num_cmds;
  logic [1:0]  mode;
  logic [3:0]  burst_len;
  logic [3:0]  gap_len;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic        busy;
  logic        wr_done;
  logic [15:0] push_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  fifo_push_gen dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .start      (start),
    .num_cmds   (num_cmds),
    .mode       (mode),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .wfull      (wfull),
    .winc       (winc),
    .wdata      (wdata),
    .busy       (busy),
    .wr_done    (wr_done),
    .push_count (push_count)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Scoreboard consumer: a push is seen at the negedge before the accepting posedge
  always @(negedge wclk) begin
    if (wrst_n && winc) begin
      if (exp_q.size() == 0) chk("extra_push", 32'd1, 32'd0);
      else chk("wdata", {24'h0, wdata}, exp_q.pop_front());
    end
    if (wrst_n && !winc && wfull) chk("stall_wdata", {24'h0, wdata}, 32'h0);
  end

  task automatic start_cmd(input int n, input logic [1:0] m, input int bl, input int gl);
    logic [31:0] l;
    l = 32'h0000_00A5;
    for (int i = 0; i < n; i++) begin
      if (m == 2'b10) exp_q.push_back(32'(i % 256));
      else begin
        exp_q.push_back({24'h0, l[7:0]});
        l = lfsr_step(l);
      end
    end
    @(posedge wclk); #1;
    start = 1'b1; num_cmds = 16'(n); mode = m;
    burst_len = 4'(bl); gap_len = 4'(gl);
    @(posedge wclk); #1;
    start = 1'b0;
  endtask

  // Counts negedges until wr_done, recording winc per cycle
  task automatic wait_done(input int budget, output int cycles, output logic [63:0] seq);
    cycles = 0;
    seq = '0;
    while (cycles < budget) begin
      @(negedge wclk);
      if (wr_done) break;
      if (cycles < 64) seq[cycles] = winc;
      cycles++;
    end
    if (!wr_done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int          cyc;
  logic [63:0] seq;

  initial begin
    wrst_n = 1'b0; start = 1'b0; num_cmds = '0; mode = 2'b00;
    burst_len = '0; gap_len = '0; wfull = 1'b0;
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    chk("rst_winc", {31'h0, winc}, 32'h0);
    chk("rst_wdata", {24'h0, wdata}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, wr_done}, 32'h0);
    chk("rst_count", {16'h0, push_count}, 32'h0);
    #1 wrst_n = 1'b1;

    // Continuous LFSR, 4 words
    start_cmd(4, 2'b00, 0, 0);
    wait_done(100, cyc, seq);
    chk("t1_pattern", seq[31:0], 32'hF);
    chk("t1_cycles", 32'(cyc), 32'd14);
    chk("t1_count", {16'h0, push_count}, 32'd4);
    chk("t1_busy", {31'h0, busy}, 32'h0);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Incrementing data, wraps at 256
    start_cmd(300, 2'b10, 0, 0);
    wait_done(400, cyc, seq);
    chk("t2_cycles", 32'(cyc), 32'd310);
    chk("t2_pattern", seq[31:0], 32'hFFFF_FFFF);
    chk("t2_count", {16'h0, push_count}, 32'd300);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Burst 3, gap 2, 7 words
    start_cmd(7, 2'b01, 3, 2);
    wait_done(100, cyc, seq);
    chk("t3_pattern", seq[31:0], 32'h4E7);
    chk("t3_cycles", 32'(cyc), 32'd21);
    chk("t3_count", {16'h0, push_count}, 32'd7);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // wfull stall for 6 cycles after the 2nd push
    start_cmd(5, 2'b00, 0, 0);
    fork
      wait_done(100, cyc, seq);
      begin
        repeat (2) @(posedge wclk);
        #1 wfull = 1'b1;
        repeat (6) @(posedge wclk);
        #1 wfull = 1'b0;
      end
    join
    chk("t4_pattern", seq[31:0], 32'h703);
    chk("t4_cycles", 32'(cyc), 32'd21);
    chk("t4_count", {16'h0, push_count}, 32'd5);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length command, then restart from DONE
    start_cmd(0, 2'b00, 0, 0);
    wait_done(100, cyc, seq);
    chk("t5_pattern", seq[31:0], 32'h0);
    chk("t5_cycles", 32'(cyc), 32'd10);
    chk("t5_done", {31'h0, wr_done}, 32'h1);
    start_cmd(2, 2'b00, 0, 0);
    @(negedge wclk);
    chk("t5_done_clr", {31'h0, wr_done}, 32'h0);
    chk("t5_count_clr", {16'h0, push_count}, 32'h0);
    chk("t5_first_word", {24'h0, wdata}, 32'hA5);
    wait_done(100, cyc, seq);
    chk("t5_count", {16'h0, push_count}, 32'd2);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset after 3 of 10 pushes
    start_cmd(10, 2'b00, 0, 0);
    repeat (3) @(posedge wclk);
    #1 wrst_n = 1'b0;
    @(negedge wclk);
    chk("t6_count_pre", {16'h0, push_count}, 32'd3);
    @(posedge wclk);
    @(negedge wclk);
    chk("t6_winc", {31'h0, winc}, 32'h0);
    chk("t6_wdata", {24'h0, wdata}, 32'h0);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_done", {31'h0, wr_done}, 32'h0);
    chk("t6_count", {16'h0, push_count}, 32'h0);
    chk("t6_sb_left", 32'(exp_q.size()), 32'd7);
    exp_q.delete();
    #1 wrst_n = 1'b1;
    repeat (3) @(negedge wclk);
    chk("t6_no_push", {31'h0, winc}, 32'h0);

    // start while busy is ignored
    start_cmd(6, 2'b10, 0, 0);
    @(posedge wclk); #1;
    start = 1'b1; num_cmds = 16'd1; mode = 2'b00;
    @(posedge wclk); #1;
    start = 1'b0;
    wait_done(100, cyc, seq);
    chk("t7_count", {16'h0, push_count}, 32'd6);
    chk("t7_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_push_gen.md
Name: fifo_push_gen

Overview:
Synthesizable write-side traffic generator for FIFO verification. It is the parametrised successor of the bench push task. It pushes a run-time-programmed number of words into a FIFO write port and honours wfull back-pressure. It supports continuous, burst-with-gap and incrementing-data modes, then raises a sticky done flag after a drain delay. It sits in the write clock domain next to the DUT and can also be used in emulation.

Parameters:
DATA_WIDTH, 8, width of wdata (1..32)
CNT_WIDTH, 16, width of num_cmds and push_count
LFSR_SEED, 32'h0000_00A5, nonzero reload value of the 32-bit data LFSR
DONE_DELAY, 10, cycles spent in DRAIN before wr_done asserts (>=1)
GAP_WIDTH, 4, width of burst_len and gap_len

Ports:
wclk  in  1  write-domain clock; all logic on posedge
wrst_n  in  1  synchronous active-low reset
start  in  1  single-cycle start pulse; honoured only in IDLE or DONE
num_cmds  in  CNT_WIDTH  number of words to push, sampled on accepted start
mode  in  2  00 continuous LFSR, 01 burst LFSR with gaps, 10 incrementing data, 11 treated as 00; sampled on start
burst_len  in  GAP_WIDTH  words per burst in mode 01; 0 treated as 1; sampled on start
gap_len  in  GAP_WIDTH  idle cycles between bursts in mode 01; sampled on start
wfull  in  1  FIFO full flag
winc  out  1  write enable to FIFO (combinational)
wdata  out  DATA_WIDTH  write data to FIFO (combinational)
busy  out  1  high in PUSH, GAP, DRAIN
wr_done  out  1  sticky completion flag
push_count  out  CNT_WIDTH  number of accepted pushes since the last start

Behaviour:
- Reset (wrst_n=0 at posedge) values:
  - state=IDLE, winc=0, wdata=0, busy=0, wr_done=0, push_count=0.
  - LFSR=LFSR_SEED, increment counter=0.
  - Reset mid-operation aborts immediately; no further pushes are made.
- FSM states: IDLE, PUSH, GAP, DRAIN, DONE.
  - IDLE/DONE + start: latch num_cmds/mode/burst_len/gap_len.
  - On that start: clear push_count, clear wr_done, reload LFSR=LFSR_SEED, clear increment counter.
  - From the start, go to PUSH; if num_cmds==0, go to DRAIN instead.
  - start in PUSH/GAP/DRAIN is ignored.
- Push rule:
  - winc = (state==PUSH) && !wfull.
  - wdata = current word when winc=1, else 0.
  - A push is accepted on every posedge with winc=1; push_count then increments by 1.
  - wfull=1 stalls: no counter, LFSR or burst advance.
- Data:
  - Modes 00/01: word = LFSR[DATA_WIDTH-1:0].
  - LFSR is a Galois 32-bit LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003).
  - LFSR step: shift right; if the old LSB was 1, XOR the mask.
  - The LFSR steps once per accepted push.
  - Mode 10: word = increment counter, starting at 0, +1 per accepted push, wrapping modulo 2^DATA_WIDTH.
- Burst (mode 01):
  - A burst counter counts accepted pushes.
  - After burst_len pushes, if gap_len!=0 and words remain: enter GAP for exactly gap_len cycles, then return to PUSH.
  - gap_len==0 means no GAP state is entered.
  - wfull has no effect in GAP.
- Completion:
  - The push that makes push_count==num_cmds moves the FSM to DRAIN next cycle.
  - The last push of a burst goes to DRAIN, never GAP.
  - DRAIN lasts DONE_DELAY cycles, then DONE.
  - In DONE: wr_done=1 and busy=0; wr_done holds until the next accepted start or reset.
- Latency: first winc can assert in the cycle after the start posedge.
- Throughput: 1 word/cycle with wfull=0, mode 00.
- push_count saturates never; num_cmds bounds it.

Test Plan:
- Reset, start with num_cmds=4, mode=00, wfull=0:
  - winc high 4 consecutive cycles.
  - First wdata=8'hA5, then the next 3 LFSR words.
  - DRAIN lasts 10 cycles, then wr_done=1 and push_count=4.
- Mode 10, num_cmds=300, DATA_WIDTH=8:
  - wdata runs 0..255 then 0..43.
  - push_count=300, no gaps.
- Mode 01, num_cmds=7, burst_len=3, gap_len=2:
  - Pattern 3 pushes, 2 idle, 3 pushes, 2 idle, 1 push, then DRAIN.
  - No GAP after the final push.
- Mode 00, num_cmds=5, wfull forced high for 6 cycles after the 2nd push:
  - winc=0 and wdata=0 during the stall.
  - The 3rd word equals the LFSR value that would follow word 2; exactly 5 pushes in total.
- num_cmds=0 → no winc ever; wr_done after 10 cycles.
  - A 2nd start in DONE with num_cmds=2 clears wr_done and reloads the seed (first wdata=8'hA5 again).
- Reset asserted during PUSH after 3 of 10 pushes:
  - All outputs 0 next cycle; state IDLE.
  - start during busy (without reset) is ignored and push_count is unaffected.
